// File: rtl/fp_add_pipe.sv
// Pipelined floating-point adder/subtractor for any EXP_W/MANT_W format with valid/ready streaming.
// Define FP_ADD_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_add_pipe #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  IN_SUB,
  input  logic [EXP_W+MANT_W:0] OP_A,
  input  logic [EXP_W+MANT_W:0] OP_B,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [EXP_W+MANT_W:0] Q,
  output logic                  FLAG_OVF,
  output logic                  FLAG_INV
);

  localparam int W    = 1 + EXP_W + MANT_W;
  localparam int MW   = MANT_W + 4;
  localparam int LZW  = $clog2(MW + 1);
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

  logic adv;
  logic out_valid_q;

  assign adv      = !out_valid_q || OUT_READY;
  assign IN_READY = adv;

  // ---------------- S1: decode / align ----------------
  logic                  sa, sb;
  logic [EXP_W-1:0]      ea, eb;
  logic [MANT_W-1:0]     ma, mb;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [W-2:0]          mag_a, mag_b;
  logic                  swap;

  assign sa     = OP_A[W-1];
  assign ea     = OP_A[W-2 -: EXP_W];
  assign ma     = OP_A[MANT_W-1:0];
  assign sb     = OP_B[W-1] ^ IN_SUB;
  assign eb     = OP_B[W-2 -: EXP_W];
  assign mb     = OP_B[MANT_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  // Denormals compare as zero so they never win the swap.
  assign mag_a  = a_zero ? '0 : OP_A[W-2:0];
  assign mag_b  = b_zero ? '0 : OP_B[W-2:0];
  assign swap   = (mag_b > mag_a);

  logic                  s1_valid_d, s1_sign_d, s1_sub_d, s1_spec_d, s1_inv_d;
  logic [EXP_W-1:0]      s1_exp_d;
  logic [MW-1:0]         s1_big_d, s1_small_d;
  logic [W-1:0]          s1_spec_val_d;
  logic [EXP_W-1:0]      e_big, e_small, shamt;
  logic [MANT_W-1:0]     m_big, m_small;
  logic                  small_zero, sticky;
  logic [MW-1:0]         ext_small, aligned;

  assign s1_valid_d = IN_VALID;
  assign s1_sub_d   = sa ^ sb;

  always_comb begin
    s1_sign_d  = sa;
    e_big      = ea;
    e_small    = eb;
    m_big      = ma;
    m_small    = mb;
    small_zero = b_zero;
    if (swap) begin
      s1_sign_d  = sb;
      e_big      = eb;
      e_small    = ea;
      m_big      = mb;
      m_small    = ma;
      small_zero = a_zero;
    end
    ext_small = small_zero ? '0 : {1'b1, m_small, 3'b000};
    shamt     = e_big - e_small;
    sticky    = 1'b0;
    for (int i = 0; i < MW; i++) begin
      if (i < int'(shamt)) sticky = sticky | ext_small[i];
    end
    aligned    = (int'(shamt) >= MW) ? '0 : (ext_small >> shamt);
    aligned[0] = aligned[0] | sticky;
    s1_exp_d   = e_big;
    s1_big_d   = {1'b1, m_big, 3'b000};
    s1_small_d = aligned;
  end

  // Specials bypass the arithmetic and ride the pipeline as a finished word.
  always_comb begin
    s1_spec_d     = 1'b0;
    s1_inv_d      = 1'b0;
    s1_spec_val_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s1_spec_d     = 1'b1;
      s1_inv_d      = 1'b1;
      s1_spec_val_d = QNAN;
    end else if (a_inf) begin
      s1_spec_d     = 1'b1;
      s1_spec_val_d = {sa, EXP_ONES, {MANT_W{1'b0}}};
    end else if (b_inf) begin
      s1_spec_d     = 1'b1;
      s1_spec_val_d = {sb, EXP_ONES, {MANT_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_spec_d     = 1'b1;
      s1_spec_val_d = {sa & sb, {(W-1){1'b0}}};
    end
  end

  logic                  s1_valid_q, s1_sign_q, s1_sub_q, s1_spec_q, s1_inv_q;
  logic [EXP_W-1:0]      s1_exp_q;
  logic [MW-1:0]         s1_big_q, s1_small_q;
  logic [W-1:0]          s1_spec_val_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_inv_q      <= 1'b0;
      s1_exp_q      <= '0;
      s1_big_q      <= '0;
      s1_small_q    <= '0;
      s1_spec_val_q <= '0;
    end else if (adv) begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_sub_q      <= s1_sub_d;
      s1_spec_q     <= s1_spec_d;
      s1_inv_q      <= s1_inv_d;
      s1_exp_q      <= s1_exp_d;
      s1_big_q      <= s1_big_d;
      s1_small_q    <= s1_small_d;
      s1_spec_val_q <= s1_spec_val_d;
    end
  end

  // ---------------- S2: add / subtract ----------------
  logic [MW:0]           s2_sum_d;
  logic                  s2_valid_q, s2_sign_q, s2_spec_q, s2_inv_q;
  logic [EXP_W-1:0]      s2_exp_q;
  logic [MW:0]           s2_sum_q;
  logic [W-1:0]          s2_spec_val_q;

  // The swap guarantees big >= small, so the difference never goes negative.
  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                             : ({1'b0, s1_big_q} + {1'b0, s1_small_q});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_inv_q      <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_spec_val_q <= '0;
    end else if (adv) begin
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s1_sign_q;
      s2_spec_q     <= s1_spec_q;
      s2_inv_q      <= s1_inv_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= s2_sum_d;
      s2_spec_val_q <= s1_spec_val_q;
    end
  end

  // ---------------- S3: normalize / round / pack ----------------
  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  logic [MW-1:0]         norm_m;
  logic [LZW-1:0]        lz;
  int                    e_n;
  logic                  inc;
  logic [MANT_W+1:0]     mant_r;
  logic [MANT_W-1:0]     frac;
  logic [W-1:0]          res_d;
  logic                  ovf_d, inv_d;

  always_comb begin
    lz = lzc(s2_sum_q[MW-1:0]);
    if (s2_sum_q[MW]) begin
      norm_m    = s2_sum_q[MW:1];
      norm_m[0] = norm_m[0] | s2_sum_q[0];
      e_n       = int'(s2_exp_q) + 1;
    end else begin
      norm_m = s2_sum_q[MW-1:0] << lz;
      e_n    = int'(s2_exp_q) - int'(lz);
    end
`ifdef FP_ADD_RNE_EN
    inc = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
`else
    inc = 1'b0;
`endif
    mant_r = {1'b0, norm_m[MW-1:3]} + (MANT_W+2)'(inc);
    frac   = mant_r[MANT_W-1:0];
    if (mant_r[MANT_W+1]) begin
      frac = '0;
      e_n  = e_n + 1;
    end
    res_d = '0;
    ovf_d = 1'b0;
    inv_d = 1'b0;
    if (s2_spec_q) begin
      res_d = s2_spec_val_q;
      inv_d = s2_inv_q;
    end else if ((s2_sum_q == '0) || (e_n <= 0)) begin
      res_d = '0;
    end else if (e_n >= EMAX) begin
      res_d = {s2_sign_q, EXP_ONES, {MANT_W{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {s2_sign_q, EXP_W'(e_n), frac};
    end
  end

`ifndef FP_ADD_RNE_EN
  logic grs_unused;
  assign grs_unused = ^norm_m[2:0];
`endif

  logic [W-1:0] q_q;
  logic         ovf_q, inv_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      q_q         <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      q_q         <= s2_valid_q ? res_d : '0;
      ovf_q       <= s2_valid_q && ovf_d;
      inv_q       <= s2_valid_q && inv_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign Q         = q_q;
  assign FLAG_OVF  = ovf_q;
  assign FLAG_INV  = inv_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: fp16 vectors, stalled streaming, mid-flight reset, one fp32 instance.
// Expected values track FP_ADD_RNE_EN so the bench matches either rounding build.
module tb_fp_add_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready, flag_ovf, flag_inv;
  logic [15:0] op_a, op_b, q;
  logic        in_valid32, in_ready32, in_sub32, out_valid32, out_ready32, flag_ovf32, flag_inv32;
  logic [31:0] op_a32, op_b32, q32;

  int n_chk = 0;
  int n_err = 0;

`ifdef FP_ADD_RNE_EN
  localparam logic [15:0] Q_RND  = 16'h3C02;
  localparam logic [15:0] Q_ROVF = 16'h7C00;
  localparam logic        F_ROVF = 1'b1;
`else
  localparam logic [15:0] Q_RND  = 16'h3C01;
  localparam logic [15:0] Q_ROVF = 16'h7BFF;
  localparam logic        F_ROVF = 1'b0;
`endif

  fp_add_pipe #(.EXP_W(5), .MANT_W(10)) dut (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_SUB(in_sub),
    .OP_A(op_a), .OP_B(op_b), .OUT_VALID(out_valid), .OUT_READY(out_ready), .Q(q),
    .FLAG_OVF(flag_ovf), .FLAG_INV(flag_inv)
  );

  fp_add_pipe #(.EXP_W(8), .MANT_W(23)) dut32 (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid32), .IN_READY(in_ready32), .IN_SUB(in_sub32),
    .OP_A(op_a32), .OP_B(op_b32), .OUT_VALID(out_valid32), .OUT_READY(out_ready32), .Q(q32),
    .FLAG_OVF(flag_ovf32), .FLAG_INV(flag_inv32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic vec(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sub,
                     input logic [15:0] eq, input logic eovf, input logic einv);
    int lat;
    @(negedge clk);
    op_a = a; op_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(lat), 64'(3));
    chk({tag, "_q"},   64'(q), 64'(eq));
    chk({tag, "_ovf"}, 64'(flag_ovf), 64'(eovf));
    chk({tag, "_inv"}, 64'(flag_inv), 64'(einv));
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] eq, input logic eovf);
    int lat;
    @(negedge clk);
    op_a32 = a; op_b32 = b; in_sub32 = sub; in_valid32 = 1'b1; out_ready32 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid32 = 1'b0;
    while (!out_valid32 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(lat), 64'(3));
    chk({tag, "_q"},   64'(q32), 64'(eq));
    chk({tag, "_ovf"}, 64'(flag_ovf32), 64'(eovf));
    chk({tag, "_inv"}, 64'(flag_inv32), 64'(0));
  endtask

  // n + 1.0 for n = 1..8; results are the next table entry.
  task automatic run_stream();
    logic [15:0] sv [9];
    int          sent, recv, cyc;
    logic        m1, m2, m3, held, exp_rdy;
    logic [15:0] hq;
    sv = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
           16'h4600, 16'h4700, 16'h4800, 16'h4880};
    sent = 0; recv = 0; cyc = 0;
    m1 = 1'b0; m2 = 1'b0; m3 = 1'b0; held = 1'b0; hq = '0;
    @(negedge clk);
    @(negedge clk);
    while (recv < 8 && cyc < 100) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid  = (sent < 8);
      op_a      = sv[(sent < 8) ? sent : 0];
      op_b      = 16'h3C00;
      in_sub    = 1'b0;
      #1;
      exp_rdy = !m3 || out_ready;
      chk("s_in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("s_out_valid", 64'(out_valid), 64'(m3));
      if (held) chk("s_hold", 64'(q), 64'(hq));
      if (out_valid && out_ready) begin
        chk("s_q", 64'(q), 64'(sv[recv + 1]));
        recv++;
      end
      held = out_valid && !out_ready;
      hq   = q;
      if (exp_rdy) begin
        m3 = m2;
        m2 = m1;
        m1 = in_valid;
        if (in_valid) sent++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("s_count", 64'(recv), 64'(8));
  endtask

  task automatic run_mid_reset();
    @(negedge clk);
    out_ready = 1'b1;
    in_sub    = 1'b0;
    op_b      = 16'h3C00;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      op_a     = 16'h4000 + 16'(k);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("r_inflight", 64'(out_valid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("r_ov_drop", 64'(out_valid), 64'(0));
    chk("r_q_zero", 64'(q), 64'(0));
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("r_no_stale", 64'(out_valid), 64'(0));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sub = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b0;
    in_valid32 = 1'b0; in_sub32 = 1'b0; op_a32 = '0; op_b32 = '0; out_ready32 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_q", 64'(q), 64'(0));
    chk("rst_ovf", 64'(flag_ovf), 64'(0));
    chk("rst_inv", 64'(flag_inv), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    vec("one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0);
    vec("five_m_one",   16'h4500, 16'h3C00, 1'b1, 16'h4400, 1'b0, 1'b0);
    vec("cancel",       16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0);
    vec("ovf",          16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0);
    vec("inf_m_inf",    16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b1);
    vec("round",        16'h3C01, 16'h1000, 1'b0, Q_RND,    1'b0, 1'b0);
    vec("tie_even",     16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, 1'b0);
    vec("round_ovf",    16'h7BFF, 16'h4C00, 1'b0, Q_ROVF,   F_ROVF, 1'b0);
    vec("far_sticky",   16'h3C00, 16'h0400, 1'b0, 16'h3C00, 1'b0, 1'b0);
    vec("two_m_one",    16'h4000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 1'b0);
    vec("neg_result",   16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0, 1'b0);
    vec("neg_plus_pos", 16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0);
    vec("nzero_nzero",  16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0);
    vec("pzero_nzero",  16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0);
    vec("denorm_flush", 16'h0001, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 1'b0);
    vec("underflow",    16'h0400, 16'h0401, 1'b1, 16'h0000, 1'b0, 1'b0);
    vec("inf_plus_fin", 16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, 1'b0);
    vec("fin_m_ninf",   16'h3C00, 16'hFC00, 1'b1, 16'h7C00, 1'b0, 1'b0);
    vec("inf_plus_inf", 16'h7C00, 16'h7C00, 1'b0, 16'h7C00, 1'b0, 1'b0);
    vec("nan_in",       16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b1);

    run_stream();

    op32("f32_one_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
    op32("f32_three_m", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0);
    op32("f32_ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1);

    run_mid_reset();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
